// File: rtl/seq_mult4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult4_pkg
// Description : Shared state type and sizing constants for seq_mult4.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mult4_pkg;

    localparam int OPW   = 4;
    localparam int PRODW = 8;
    localparam int ITERS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fourbit.sv
`default_nettype none
// ============================================================================
// Module      : fourbit
// Description : 4-bit ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
module fourbit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_carry_in,
    output logic [3:0] o_sum,
    output logic       o_carry_out
);

    logic [4:0] w_c;

    assign w_c[0] = i_carry_in;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_carry_out = w_c[4];

endmodule
`default_nettype wire

// File: rtl/seq_mult4.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult4
// Description : 4x4 unsigned shift-add sequential multiplier, 4 iterations.
//               Optional macro SEQ_MULT4_ZERO_SKIP_EN: zero operands finish
//               in one cycle without entering BUSY.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult4
    import seq_mult4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   inA,
    input  logic [OPW-1:0]   inB,
    output logic [PRODW-1:0] product,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_next;
    logic [OPW-1:0]   r_mcand;
    logic [OPW-1:0]   r_mplier;
    logic [PRODW-1:0] r_acc;
    logic [1:0]       r_cnt;

    logic             w_accept;
    logic             w_skip;
    logic             w_last;
    logic [OPW-1:0]   w_addend;
    logic [OPW-1:0]   w_sum;
    logic             w_cout;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == 2'(ITERS - 1));
    assign w_addend = r_mplier[0] ? r_mcand : '0;

`ifdef SEQ_MULT4_ZERO_SKIP_EN
    assign w_skip = (inA == '0) || (inB == '0);
`else
    assign w_skip = 1'b0;
`endif

    fourbit u_add (
        .i_a         (r_acc[PRODW-1:OPW]),
        .i_b         (w_addend),
        .i_carry_in  (1'b0),
        .o_sum       (w_sum),
        .o_carry_out (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = w_skip ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next = w_skip ? ST_DONE : ST_BUSY;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Accumulator shifts right each iteration; the counter wraps 3->0 into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_mcand  <= inA;
            r_mplier <= inB;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == ST_BUSY) begin
            r_acc    <= {w_cout, w_sum, r_acc[OPW-1:1]};
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 2'd1;
        end
    end

    assign product = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult4.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult4
// Description : Self-checking bench for seq_mult4 (vector table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] inA;
    logic [3:0] inB;
    logic [7:0] product;
    logic       busy;
    logic       done;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs[12];

    seq_mult4 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .inA     (inA),
        .inB     (inB),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE or DONE; returns at the done negedge.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_p);
        int cyc;
        int bc;
        int exp_lat;
        exp_lat = 5;
`ifdef SEQ_MULT4_ZERO_SKIP_EN
        if (a == 4'd0 || b == 4'd0) exp_lat = 1;
`endif
        start = 1'b1;
        inA   = a;
        inB   = b;
        @(negedge clk);
        start = 1'b0;
        inA   = ~a;
        inB   = ~b;
        cyc   = 1;
        bc    = 0;
        while (!done && cyc < 20) begin
            if (busy) bc++;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        chk("busy_cycles", bc, exp_lat - 1);
        chk("product", int'(product), int'(exp_p));
        chk("busy_at_done", int'(busy), 0);
    endtask

    task automatic idle_check(input logic [7:0] exp_p);
        @(negedge clk);
        chk("done_single_pulse", int'(done), 0);
        chk("busy_idle", int'(busy), 0);
        chk("product_held", int'(product), int'(exp_p));
    endtask

    initial begin
        int cyc;
        int t1;
        int t2;
        int gap;
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{4'd15, 4'd15, 8'hE1};
        vecs[1]  = '{4'd0,  4'd9,  8'h00};
        vecs[2]  = '{4'd3,  4'd5,  8'h0F};
        vecs[3]  = '{4'd1,  4'd15, 8'h0F};
        vecs[4]  = '{4'd10, 4'd12, 8'h78};
        vecs[5]  = '{4'd2,  4'd6,  8'h0C};
        vecs[6]  = '{4'd7,  4'd7,  8'h31};
        vecs[7]  = '{4'd8,  4'd1,  8'h08};
        vecs[8]  = '{4'd9,  4'd0,  8'h00};
        vecs[9]  = '{4'd15, 4'd1,  8'h0F};
        vecs[10] = '{4'd1,  4'd1,  8'h01};
        vecs[11] = '{4'd12, 4'd13, 8'h9C};

        rst   = 1'b1;
        start = 1'b0;
        inA   = 4'd0;
        inB   = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_product", int'(product), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].p);
            idle_check(vecs[i].p);
        end

        // start pulsed during BUSY must be ignored
        start = 1'b1; inA = 4'd3; inB = 4'd5;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        @(negedge clk);
        start = 1'b1; inA = 4'd7; inB = 4'd7; cyc++;
        @(negedge clk);
        start = 1'b0; cyc++;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ignore_start_latency", cyc, 5);
        chk("ignore_start_product", int'(product), 8'h0F);
        idle_check(8'h0F);

        // reset in the second BUSY cycle discards the operation
        start = 1'b1; inA = 4'd9; inB = 4'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_product", int'(product), 0);
        @(negedge clk);
        chk("midrst_still_idle", int'(busy) + int'(done), 0);
        do_op(4'd2, 4'd6, 8'h0C);
        idle_check(8'h0C);

        // back-to-back with start held high
        start = 1'b1; inA = 4'd1; inB = 4'd15;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 20);
        t1 = cyc;
        chk("b2b_first_latency", t1, 5);
        chk("b2b_first_product", int'(product), 8'h0F);
        inA = 4'd10; inB = 4'd12;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 40);
        t2 = cyc;
        start = 1'b0;
        chk("b2b_spacing", t2 - t1, 5);
        chk("b2b_second_product", int'(product), 8'h78);
        idle_check(8'h78);

        // exhaustive operands with random gaps
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                do_op(4'(ia), 4'(ib), 8'(ia * ib));
                gap = int'($urandom_range(0, 3));
                if (gap > 0) begin
                    idle_check(8'(ia * ib));
                    repeat (gap - 1) @(negedge clk);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
